// File: rtl/lsq_buffer.sv
// In-order load/store queue: CDB wakeup, strictly ordered memory issue and a single result port.
// Optional LSB_MISALIGN_EN: misaligned h/w accesses retire with out_exc instead of a memory request.
module lsq_buffer #(
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned TAG_W       = 4,
  parameter int unsigned CDB_N       = 2,
  parameter int unsigned FULL_MARGIN = 3,
  parameter logic [31:0] IO_BASE     = 32'h0003_0000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rdy,
  input  logic                   flush,
  input  logic                   in_valid,
  input  logic [3:0]             in_op,
  input  logic [TAG_W-1:0]       in_tag,
  input  logic [11:0]            in_imm,
  input  logic [31:0]            in_base_val,
  input  logic [31:0]            in_data_val,
  input  logic                   in_base_busy,
  input  logic                   in_data_busy,
  input  logic [TAG_W-1:0]       in_base_tag,
  input  logic [TAG_W-1:0]       in_data_tag,
  input  logic [CDB_N-1:0]       cdb_valid,
  input  logic [CDB_N*TAG_W-1:0] cdb_tag,
  input  logic [CDB_N*32-1:0]    cdb_data,
  input  logic [TAG_W-1:0]       rob_head_tag,
  output logic                   in_ready,
  output logic                   mem_req,
  output logic [3:0]             mem_op,
  output logic [31:0]            mem_addr,
  output logic [31:0]            mem_wdata,
  input  logic                   mem_ack,
  input  logic [31:0]            mem_rdata,
  output logic                   out_valid,
  output logic [TAG_W-1:0]       out_tag,
  output logic [31:0]            out_data,
  output logic                   out_exc
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] DepthC   = CW'(DEPTH);
  localparam logic [CW-1:0] ReadyLim = CW'(DEPTH - FULL_MARGIN);

  typedef enum logic [0:0] {StIdle, StWait} state_e;

  state_e r_state, w_state_next;

  logic             r_valid     [DEPTH];
  logic [3:0]       r_op        [DEPTH];
  logic [TAG_W-1:0] r_tag       [DEPTH];
  logic [11:0]      r_imm       [DEPTH];
  logic [31:0]      r_base_val  [DEPTH];
  logic [31:0]      r_data_val  [DEPTH];
  logic             r_base_busy [DEPTH];
  logic             r_data_busy [DEPTH];
  logic [TAG_W-1:0] r_base_tag  [DEPTH];
  logic [TAG_W-1:0] r_data_tag  [DEPTH];

  logic [PW-1:0]    r_head, r_tail;
  logic [CW-1:0]    r_count, w_count_next;
  logic             r_in_ready;
  logic             r_mem_req, w_mem_req_d;
  logic [3:0]       r_mem_op, w_mem_op_d;
  logic [31:0]      r_mem_addr, w_mem_addr_d, r_mem_wdata, w_mem_wdata_d;
  logic             r_out_valid, w_out_valid_d;
  logic [TAG_W-1:0] r_out_tag, w_out_tag_d;
  logic [31:0]      r_out_data, w_out_data_d;

  logic [32:0] w_base_wk [DEPTH];
  logic [32:0] w_data_wk [DEPTH];
  logic [32:0] w_in_base_wk, w_in_data_wk;
  logic [31:0] w_addr;
  logic        w_eligible, w_issue_ok, w_misalign, w_retire, w_enq;

  // {hit, data}; iterating downwards lets the lowest matching channel win.
  function automatic logic [32:0] cdb_lookup(input logic [TAG_W-1:0] tag,
                                             input logic [CDB_N-1:0] v,
                                             input logic [CDB_N*TAG_W-1:0] t,
                                             input logic [CDB_N*32-1:0] d);
    logic [32:0] res;
    res = '0;
    for (int c = CDB_N - 1; c >= 0; c--) begin
      if (v[c] && (t[c*TAG_W +: TAG_W] == tag)) res = {1'b1, d[c*32 +: 32]};
    end
    return res;
  endfunction

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      w_base_wk[i] = cdb_lookup(r_base_tag[i], cdb_valid, cdb_tag, cdb_data);
      w_data_wk[i] = cdb_lookup(r_data_tag[i], cdb_valid, cdb_tag, cdb_data);
    end
    w_in_base_wk = cdb_lookup(in_base_tag, cdb_valid, cdb_tag, cdb_data);
    w_in_data_wk = cdb_lookup(in_data_tag, cdb_valid, cdb_tag, cdb_data);
  end

  assign w_addr     = r_base_val[r_head] + {{20{r_imm[r_head][11]}}, r_imm[r_head]};
  assign w_eligible = (!r_op[r_head][3] && (w_addr != IO_BASE)) ||
                      (r_tag[r_head] == rob_head_tag);
  assign w_issue_ok = (r_state == StIdle) && (r_count != '0) && !r_base_busy[r_head] &&
                      !r_data_busy[r_head] && w_eligible;

`ifdef LSB_MISALIGN_EN
  assign w_misalign = ((r_op[r_head][1:0] == 2'b01) && w_addr[0]) ||
                      ((r_op[r_head][1:0] == 2'b10) && (w_addr[1:0] != 2'b00));
`else
  assign w_misalign = 1'b0;
`endif

  assign w_retire = !flush && (((r_state == StWait) && mem_ack) || (w_issue_ok && w_misalign));
  assign w_enq    = !flush && in_valid && (r_count != DepthC);
  assign w_count_next = flush ? '0 : r_count + CW'(w_enq) - CW'(w_retire);

  always_ff @(posedge clk) begin
    if (!rst)     r_state <= StIdle;
    else if (rdy) r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: if (w_issue_ok && !w_misalign) w_state_next = StWait;
      StWait: if (mem_ack) w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
    if (flush) w_state_next = StIdle;
  end

  always_comb begin
    w_mem_req_d   = r_mem_req;
    w_mem_op_d    = r_mem_op;
    w_mem_addr_d  = r_mem_addr;
    w_mem_wdata_d = r_mem_wdata;
    w_out_valid_d = 1'b0;
    w_out_tag_d   = r_out_tag;
    w_out_data_d  = r_out_data;
    if (w_issue_ok && w_misalign) begin
      w_out_valid_d = 1'b1;
      w_out_tag_d   = r_tag[r_head];
      w_out_data_d  = w_addr;
    end else if (w_issue_ok) begin
      w_mem_req_d   = 1'b1;
      w_mem_op_d    = r_op[r_head];
      w_mem_addr_d  = w_addr;
      w_mem_wdata_d = r_data_val[r_head];
    end else if ((r_state == StWait) && mem_ack) begin
      w_mem_req_d   = 1'b0;
      w_out_valid_d = 1'b1;
      w_out_tag_d   = r_tag[r_head];
      w_out_data_d  = r_op[r_head][3] ? 32'h0 : mem_rdata;
    end
    if (flush) begin
      w_mem_req_d   = 1'b0;
      w_out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_head      <= '0;
      r_tail      <= '0;
      r_count     <= '0;
      r_in_ready  <= 1'b1;
      r_mem_req   <= 1'b0;
      r_mem_op    <= '0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_out_valid <= 1'b0;
      r_out_tag   <= '0;
      r_out_data  <= '0;
      for (int i = 0; i < DEPTH; i++) r_valid[i] <= 1'b0;
    end else if (rdy) begin
      r_count     <= w_count_next;
      r_in_ready  <= w_count_next < ReadyLim;
      r_mem_req   <= w_mem_req_d;
      r_mem_op    <= w_mem_op_d;
      r_mem_addr  <= w_mem_addr_d;
      r_mem_wdata <= w_mem_wdata_d;
      r_out_valid <= w_out_valid_d;
      r_out_tag   <= w_out_tag_d;
      r_out_data  <= w_out_data_d;
      if (flush) begin
        r_head <= '0;
        r_tail <= '0;
        for (int i = 0; i < DEPTH; i++) r_valid[i] <= 1'b0;
      end else begin
        for (int i = 0; i < DEPTH; i++) begin
          if (r_valid[i] && r_base_busy[i] && w_base_wk[i][32]) begin
            r_base_busy[i] <= 1'b0;
            r_base_val[i]  <= w_base_wk[i][31:0];
          end
          if (r_valid[i] && r_data_busy[i] && w_data_wk[i][32]) begin
            r_data_busy[i] <= 1'b0;
            r_data_val[i]  <= w_data_wk[i][31:0];
          end
        end
        if (w_retire) begin
          r_valid[r_head] <= 1'b0;
          r_head          <= r_head + PW'(1);
        end
        if (w_enq) begin
          r_valid[r_tail]     <= 1'b1;
          r_op[r_tail]        <= in_op;
          r_tag[r_tail]       <= in_tag;
          r_imm[r_tail]       <= in_imm;
          r_base_tag[r_tail]  <= in_base_tag;
          r_data_tag[r_tail]  <= in_data_tag;
          r_base_busy[r_tail] <= in_base_busy && !w_in_base_wk[32];
          r_data_busy[r_tail] <= in_data_busy && !w_in_data_wk[32];
          r_base_val[r_tail]  <= (in_base_busy && w_in_base_wk[32]) ? w_in_base_wk[31:0]
                                                                    : in_base_val;
          r_data_val[r_tail]  <= (in_data_busy && w_in_data_wk[32]) ? w_in_data_wk[31:0]
                                                                    : in_data_val;
          r_tail              <= r_tail + PW'(1);
        end
      end
    end
  end

`ifdef LSB_MISALIGN_EN
  logic r_out_exc;
  always_ff @(posedge clk) begin
    if (!rst)     r_out_exc <= 1'b0;
    else if (rdy) r_out_exc <= !flush && w_issue_ok && w_misalign;
  end
  assign out_exc = r_out_exc;
`else
  assign out_exc = 1'b0;
`endif

  assign in_ready  = r_in_ready;
  assign mem_req   = r_mem_req;
  assign mem_op    = r_mem_op;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign out_valid = r_out_valid;
  assign out_tag   = r_out_tag;
  assign out_data  = r_out_data;

endmodule

// File: tb/tb_lsq_buffer.sv
// Directed bench for lsq_buffer: issue latency, wakeup/bypass, fill/wrap order, IO gating, flush,
// and misalignment handling (behaviour depends on LSB_MISALIGN_EN).
module tb_lsq_buffer;

  localparam int unsigned TAG_W = 4;
  localparam int unsigned CDB_N = 2;
  localparam logic [31:0] IoBase = 32'h0003_0000;

  logic                   clk = 1'b0;
  logic                   rst, rdy, flush, in_valid;
  logic [3:0]             in_op;
  logic [TAG_W-1:0]       in_tag, in_base_tag, in_data_tag, rob_head_tag;
  logic [11:0]            in_imm;
  logic [31:0]            in_base_val, in_data_val, mem_rdata;
  logic                   in_base_busy, in_data_busy, mem_ack;
  logic [CDB_N-1:0]       cdb_valid;
  logic [CDB_N*TAG_W-1:0] cdb_tag;
  logic [CDB_N*32-1:0]    cdb_data;
  logic                   in_ready, mem_req, out_valid, out_exc;
  logic [3:0]             mem_op;
  logic [31:0]            mem_addr, mem_wdata, out_data;
  logic [TAG_W-1:0]       out_tag;

  int checks = 0;
  int failures = 0;

  lsq_buffer #(.DEPTH(16), .TAG_W(TAG_W), .CDB_N(CDB_N), .FULL_MARGIN(3), .IO_BASE(IoBase)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush), .in_valid(in_valid), .in_op(in_op),
    .in_tag(in_tag), .in_imm(in_imm), .in_base_val(in_base_val), .in_data_val(in_data_val),
    .in_base_busy(in_base_busy), .in_data_busy(in_data_busy), .in_base_tag(in_base_tag),
    .in_data_tag(in_data_tag), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .rob_head_tag(rob_head_tag), .in_ready(in_ready), .mem_req(mem_req), .mem_op(mem_op),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .out_valid(out_valid), .out_tag(out_tag), .out_data(out_data), .out_exc(out_exc)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  // One dispatch edge; operand fields as given, then in_valid drops.
  task automatic enq(input logic [3:0] op, input logic [TAG_W-1:0] tag, input logic [11:0] imm,
                     input logic [31:0] base, input logic [31:0] data,
                     input logic dbusy, input logic [TAG_W-1:0] dtag);
    in_valid = 1'b1; in_op = op; in_tag = tag; in_imm = imm;
    in_base_val = base; in_base_busy = 1'b0; in_base_tag = '0;
    in_data_val = data; in_data_busy = dbusy; in_data_tag = dtag;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_req(input string name);
    int n = 0;
    while (!mem_req && n < 20) begin
      tick();
      n++;
    end
    chk(name, {31'h0, mem_req}, 32'h1);
  endtask

  task automatic ack(input logic [31:0] rdata);
    mem_ack = 1'b1; mem_rdata = rdata;
    tick();
    mem_ack = 1'b0; mem_rdata = '0;
  endtask

  initial begin
    rst = 1'b0; rdy = 1'b1; flush = 1'b0; in_valid = 1'b0; in_op = '0; in_tag = '0;
    in_imm = '0; in_base_val = '0; in_data_val = '0; in_base_busy = 1'b0; in_data_busy = 1'b0;
    in_base_tag = '0; in_data_tag = '0; cdb_valid = '0; cdb_tag = '0; cdb_data = '0;
    rob_head_tag = 4'hF; mem_ack = 1'b0; mem_rdata = '0;
    tick(); tick();
    rst = 1'b1;
    chk("rst_mem_req", {31'h0, mem_req}, 32'h0);
    chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
    chk("rst_in_ready", {31'h0, in_ready}, 32'h1);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_out_data", out_data, 32'h0);
    chk("rst_out_exc", {31'h0, out_exc}, 32'h0);

    // lw base 0x100 imm -4
    enq(4'b0010, 4'd1, 12'hFFC, 32'h100, 32'h0, 1'b0, '0);
    chk("lw_no_req_yet", {31'h0, mem_req}, 32'h0);
    tick();
    chk("lw_req", {31'h0, mem_req}, 32'h1);
    chk("lw_addr", mem_addr, 32'hFC);
    chk("lw_op", {28'h0, mem_op}, 32'h2);
    tick();
    chk("lw_req_hold", {31'h0, mem_req}, 32'h1);
    chk("lw_addr_hold", mem_addr, 32'hFC);
    ack(32'hDEAD_BEEF);
    chk("lw_out_valid", {31'h0, out_valid}, 32'h1);
    chk("lw_out_tag", {28'h0, out_tag}, 32'h1);
    chk("lw_out_data", out_data, 32'hDEAD_BEEF);
    chk("lw_req_drop", {31'h0, mem_req}, 32'h0);
    tick();
    chk("lw_pulse_end", {31'h0, out_valid}, 32'h0);

    // sw waiting on data tag 5 and on ROB head
    enq(4'b1010, 4'd3, 12'h000, 32'h200, 32'h0, 1'b1, 4'd5);
    tick(); tick();
    chk("sw_wait_data", {31'h0, mem_req}, 32'h0);
    cdb_valid = 2'b11; cdb_tag = {4'd5, 4'd6}; cdb_data = {32'h55, 32'h66};
    tick();
    cdb_valid = '0;
    tick(); tick();
    chk("sw_wait_head", {31'h0, mem_req}, 32'h0);
    rob_head_tag = 4'd3;
    tick();
    chk("sw_req", {31'h0, mem_req}, 32'h1);
    chk("sw_wdata", mem_wdata, 32'h55);
    chk("sw_addr", mem_addr, 32'h200);
    ack(32'h1234_5678);
    chk("sw_out_valid", {31'h0, out_valid}, 32'h1);
    chk("sw_out_tag", {28'h0, out_tag}, 32'h3);
    chk("sw_out_data", out_data, 32'h0);

    // dispatch-time bypass, both channels match: channel 0 wins
    rob_head_tag = 4'd4;
    cdb_valid = 2'b11; cdb_tag = {4'd9, 4'd9}; cdb_data = {32'hA1, 32'hA0};
    enq(4'b1010, 4'd4, 12'h004, 32'h300, 32'h0, 1'b1, 4'd9);
    cdb_valid = '0;
    tick();
    chk("byp_req", {31'h0, mem_req}, 32'h1);
    chk("byp_wdata", mem_wdata, 32'hA0);
    chk("byp_addr", mem_addr, 32'h304);
    ack(32'h0);
    rob_head_tag = 4'hF;
    tick();

    // fill to DEPTH with ack low
    for (int k = 1; k <= 16; k++) begin
      enq(4'b0010, 4'(k - 1), 12'h000, 32'h1000 + 32'((k - 1) * 16), 32'h0, 1'b0, '0);
      chk($sformatf("fill_in_ready_%0d", k), {31'h0, in_ready}, {31'h0, k < 13});
    end
    enq(4'b0010, 4'hE, 12'h000, 32'h0000_BAD0, 32'h0, 1'b0, '0);
    chk("full_in_ready", {31'h0, in_ready}, 32'h0);
    for (int j = 0; j < 16; j++) begin
      wait_req($sformatf("drain_req_%0d", j));
      chk($sformatf("drain_addr_%0d", j), mem_addr, 32'h1000 + 32'(j * 16));
      ack(32'h5000 + 32'(j));
      chk($sformatf("drain_tag_%0d", j), {28'h0, out_tag}, 32'(j));
      chk($sformatf("drain_data_%0d", j), out_data, 32'h5000 + 32'(j));
    end
    tick(); tick();
    chk("no_17th", {31'h0, mem_req}, 32'h0);
    chk("drained_ready", {31'h0, in_ready}, 32'h1);

    // second batch across the wrap
    for (int j = 0; j < 10; j++) enq(4'b0010, 4'(j), 12'h000, 32'h2000 + 32'(j * 4), 32'h0, 1'b0, '0);
    for (int j = 0; j < 10; j++) begin
      wait_req($sformatf("wrap_req_%0d", j));
      chk($sformatf("wrap_addr_%0d", j), mem_addr, 32'h2000 + 32'(j * 4));
      ack(32'h7000 + 32'(j));
      chk($sformatf("wrap_tag_%0d", j), {28'h0, out_tag}, 32'(j));
    end
    tick();

    // IO_BASE load waits for ROB head; IO_BASE+4 does not
    enq(4'b0010, 4'd6, 12'h000, IoBase, 32'h0, 1'b0, '0);
    tick(); tick(); tick();
    chk("io_hold", {31'h0, mem_req}, 32'h0);
    rob_head_tag = 4'd6;
    tick();
    chk("io_req", {31'h0, mem_req}, 32'h1);
    chk("io_addr", mem_addr, IoBase);
    ack(32'h0);
    tick();
    enq(4'b0010, 4'd7, 12'h004, IoBase, 32'h0, 1'b0, '0);
    tick();
    chk("io4_req", {31'h0, mem_req}, 32'h1);
    chk("io4_addr", mem_addr, IoBase + 32'h4);
    ack(32'h0);
    rob_head_tag = 4'hF;
    tick();

    // flush in WAIT with same-cycle enqueue and ack
    enq(4'b0010, 4'd8, 12'h000, 32'h400, 32'h0, 1'b0, '0);
    tick();
    chk("fl_req_before", {31'h0, mem_req}, 32'h1);
    flush = 1'b1; mem_ack = 1'b1; mem_rdata = 32'hFFFF_0000;
    in_valid = 1'b1; in_op = 4'b0010; in_tag = 4'd9; in_base_val = 32'h500; in_imm = '0;
    tick();
    flush = 1'b0; mem_ack = 1'b0; in_valid = 1'b0;
    chk("fl_req", {31'h0, mem_req}, 32'h0);
    chk("fl_out_valid", {31'h0, out_valid}, 32'h0);
    chk("fl_in_ready", {31'h0, in_ready}, 32'h1);
    tick(); tick();
    chk("fl_enq_dropped", {31'h0, mem_req}, 32'h0);
    chk("fl_no_out", {31'h0, out_valid}, 32'h0);

    // rdy low: dispatch is not taken
    rdy = 1'b0;
    enq(4'b0010, 4'd11, 12'h000, 32'h600, 32'h0, 1'b0, '0);
    rdy = 1'b1;
    tick(); tick();
    chk("rdy_hold", {31'h0, mem_req}, 32'h0);

    // lw at 0x102
    enq(4'b0010, 4'd10, 12'h000, 32'h102, 32'h0, 1'b0, '0);
    tick();
`ifdef LSB_MISALIGN_EN
    chk("mis_no_req", {31'h0, mem_req}, 32'h0);
    chk("mis_out_valid", {31'h0, out_valid}, 32'h1);
    chk("mis_out_exc", {31'h0, out_exc}, 32'h1);
    chk("mis_out_data", out_data, 32'h102);
    chk("mis_out_tag", {28'h0, out_tag}, 32'hA);
    tick();
    chk("mis_pulse_end", {31'h0, out_valid}, 32'h0);
`else
    chk("mis_off_req", {31'h0, mem_req}, 32'h1);
    chk("mis_off_addr", mem_addr, 32'h102);
    ack(32'hCAFE);
    chk("mis_off_valid", {31'h0, out_valid}, 32'h1);
    chk("mis_off_exc", {31'h0, out_exc}, 32'h0);
    chk("mis_off_data", out_data, 32'hCAFE);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
